coherence_ctrl: RTL and testbench
=================================

# coherence_ctrl

Snooping coherence/bus controller for the two-core data side. It sits between the two dcaches and the single RAM port. It arbitrates writebacks and miss fills, and broadcasts snoops (`ccwait`, `ccsnoopaddr`, `ccinv`) to the non-requesting cache. When the snooped cache reports dirty data, it forwards that data cache-to-cache while also writing it to RAM; otherwise it fills the requester from RAM.

## Interface
- Parameters: none. Two cores are fixed; index 0/1 selects the core on every per-core bus.
- `CLK` in 1: system clock.
- `nRST` in 1: reset. One clock; reset is asynchronous and active-low.
- `dREN` in [1:0]: per-core read request (miss fill).
- `dWEN` in [1:0]: per-core write request (eviction, flush or snoop writeback).
- `daddr` in [1:0][31:0]: per-core word address.
- `dstore` in [1:0][31:0]: per-core write data.
- `cctrans` in [1:0]: per-core coherence request qualifier for reads; snoop response "dirty, will write back" while snooped.
- `ccwrite` in [1:0]: per-core intent-to-modify; sampled at grant.
- `dwait` out [1:0]: per-core stall; 0 for exactly the cycle a word completes.
- `dload` out [1:0][31:0]: per-core read data, valid when `dwait` = 0.
- `ccwait` out [1:0]: per-core "you are being snooped".
- `ccinv` out [1:0]: per-core invalidate qualifier during snoop.
- `ccsnoopaddr` out [1:0][31:0]: per-core snoop address.
- `ramREN`, `ramWEN` out 1 each: RAM strobes.
- `ramaddr`, `ramstore` out 32 each.
- `ramload` in 32: RAM read data.
- `ramready` in 1: RAM access completes this cycle.

## Operation
- States: IDLE, WB, SNOOP, C2C1, C2C2, RD1, RD2.
- Registers:
  - `req`: granted core, 1 bit.
  - `last`: round-robin pointer, 1 bit.
  - `inv`: latched `ccwrite[req]`.
  - `dirty`: latched snoop response.
  - `oth` = ~`req`.
- IDLE:
  - Writebacks win over reads. Any `dWEN[i]` with `cctrans` unqualified → grant, go to WB.
  - Otherwise `dREN[i]` & `cctrans[i]` → grant, latch `inv` ← `ccwrite[i]`, go to SNOOP.
  - Both cores eligible in the same class → grant ~`last`. `last` ← granted core on every grant.
- WB:
  - Pass through: `ramWEN`=1, `ramaddr`=`daddr[req]`, `ramstore`=`dstore[req]`.
  - `dwait[req]` = ~`ramready`.
  - Stay while `dWEN[req]`, so multi-word flushes stream. Drop of `dWEN[req]` → IDLE.
- SNOOP (exactly 1 cycle):
  - Drive `ccwait[oth]`=1, `ccsnoopaddr[oth]`=`daddr[req]`, `ccinv[oth]`=`inv`.
  - Latch `dirty` ← `cctrans[oth]`.
  - `dirty` → C2C1; else RD1.
- C2C1 / C2C2:
  - `ccwait[oth]`, `ccinv[oth]`, `ccsnoopaddr[oth]` held.
  - RAM written from the snooper: `ramWEN`=`dWEN[oth]`, `ramaddr`=`daddr[oth]`, `ramstore`=`dstore[oth]`.
  - `dload[req]`=`dstore[oth]`.
  - On `ramready`: `dwait[req]`=0, `dwait[oth]`=0, advance C2C1→C2C2→IDLE.
  - A read that is not shared also drops the line in the snooper via `ccinv`.
- RD1 / RD2:
  - `ccwait[oth]` held high through RD1 so a clean invalidation completes, then low.
  - `ramREN`=1, `ramaddr`=`daddr[req]`, `dload[req]`=`ramload`.
  - `ramready` → `dwait[req]`=0, advance RD1→RD2→IDLE.
- Defaults: `dwait`=2'b11; all other outputs 0. A core never sees `ccwait` while it is `req`.

## Timing
- Reset (async, immediate):
  - State IDLE; `last`=1 so core 0 wins the first tie; `req`/`inv`/`dirty`=0.
  - Outputs: `dwait`=11, `ccwait`=00, `ccinv`=00, `ccsnoopaddr`=0, `dload`=0, RAM strobes 0.
  - Reset mid-transaction abandons it; strobes drop combinationally.
- Latency with a RAM of k wait cycles (ramready on cycle k+1 of an access):
  - Clean miss: 1 (IDLE grant) + 1 (SNOOP) + 2(k+1).
  - Dirty-shared miss: same total.
  - Writeback: k+1 per word.
- `ccwait[oth]` rises the cycle after grant. It falls the cycle after the last C2C2 word or after RD1 completes.
- `dwait` low is a single-cycle pulse per word. A word completes only on `ramready`=1 in the matching state.
- Boundaries:
  - Request withdrawn in IDLE before grant → ignored.
  - `dREN` without `cctrans` → not granted.
  - Simultaneous `dWEN[0]` and `dREN[1]` → core 0 WB first, core 1 granted next IDLE.
  - Writeback by `oth` during SNOOP/RD → held off (its `dwait`=1).

## Test plan
- Reset with all inputs 0 → `dwait`=11, `ccwait`=00, `ramREN`=`ramWEN`=0; hold 5 cycles, no change.
- Core 0 clean read of 0x100, `cctrans[1]`=0, ramready every cycle → `ccwait[1]`=1 with `ccsnoopaddr[1]`=0x100, `ccinv[1]`=0; `dload[0]` = RAM[0x100], then RAM[0x104]; `dwait[0]` low on 2 cycles; done 4 cycles after request.
- Core 1 write-miss 0x200 (`ccwrite[1]`=1), core 0 answers `cctrans[0]`=1 with `dstore` 0xAAAA/0xBBBB → `ccinv[0]`=1; `dload[1]`=0xAAAA then 0xBBBB; RAM[0x200]=0xAAAA, RAM[0x204]=0xBBBB.
- Both cores assert read requests in the same cycle after reset → core 0 served first; repeat → core 1 served first.
- Core 0 flush of 4 words, ramready with 2-cycle latency → 4 `dwait[0]` pulses spaced 3 cycles apart; core 1 read pending meanwhile granted only after `dWEN[0]` drops.
- Assert `nRST`=0 in C2C1 → all outputs return to reset values in the same cycle; next request is processed normally.

Source files
------------

// File: rtl/coherence_ctrl_if.sv
// Bus bundle between the two dcaches, the RAM port and the coherence controller.
// Index 0/1 on every per-core field selects the core.
interface coherence_ctrl_if;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       cctrans;
    logic [1:0]       ccwrite;
    logic [1:0]       dwait;
    logic [1:0][31:0] dload;
    logic [1:0]       ccwait;
    logic [1:0]       ccinv;
    logic [1:0][31:0] ccsnoopaddr;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic             ramready;

    // master: the caches plus RAM; slave: the coherence controller
    modport master (
        output dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramready,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
    );
    modport slave (
        input  dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramready,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_ctrl.sv
// Snooping coherence controller for two dcaches sharing one RAM port.
// Arbitrates writebacks over miss fills, snoops the other cache, and forwards dirty data cache-to-cache.
module coherence_ctrl (
    input  logic             CLK,
    input  logic             nRST,
    coherence_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C1, C2C2, RD1, RD2} state_t;

    state_t     state, next_state;
    logic       req, req_n;
    logic       last, last_n;
    logic       inv, inv_n;
    logic       dirty, dirty_n;
    logic       oth;
    logic [1:0] wb_el, rd_el;
    logic       wb_gnt, rd_gnt;

    // Tie goes to the core that was not granted last.
    function automatic logic pick(input logic [1:0] el, input logic lst);
        return (el == 2'b11) ? ~lst : el[1];
    endfunction

    assign oth    = ~req;
    assign wb_el  = bus.dWEN;
    assign rd_el  = bus.dREN & bus.cctrans;
    assign wb_gnt = pick(wb_el, last);
    assign rd_gnt = pick(rd_el, last);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            req   <= 1'b0;
            last  <= 1'b1;
            inv   <= 1'b0;
            dirty <= 1'b0;
        end else begin
            state <= next_state;
            req   <= req_n;
            last  <= last_n;
            inv   <= inv_n;
            dirty <= dirty_n;
        end
    end

    always_comb begin
        next_state      = state;
        req_n           = req;
        last_n          = last;
        inv_n           = inv;
        dirty_n         = dirty;
        bus.dwait       = 2'b11;
        bus.dload       = '0;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;

        case (state)
            IDLE: begin
                if (|wb_el) begin
                    req_n      = wb_gnt;
                    last_n     = wb_gnt;
                    next_state = WB;
                end else if (|rd_el) begin
                    req_n      = rd_gnt;
                    last_n     = rd_gnt;
                    inv_n      = bus.ccwrite[rd_gnt];
                    next_state = SNOOP;
                end
            end

            // Streams words while the writer holds dWEN; the drop cycle issues no RAM write.
            WB: begin
                bus.ramWEN     = bus.dWEN[req];
                bus.ramaddr    = bus.daddr[req];
                bus.ramstore   = bus.dstore[req];
                bus.dwait[req] = ~(bus.ramready & bus.dWEN[req]);
                if (!bus.dWEN[req])
                    next_state = IDLE;
            end

            SNOOP: begin
                bus.ccwait[oth]      = 1'b1;
                bus.ccsnoopaddr[oth] = bus.daddr[req];
                bus.ccinv[oth]       = inv;
                dirty_n              = bus.cctrans[oth];
                next_state           = bus.cctrans[oth] ? C2C1 : RD1;
            end

            // Snooper's writeback goes to RAM and to the requester in the same word.
            C2C1, C2C2: begin
                bus.ccwait[oth]      = 1'b1;
                bus.ccsnoopaddr[oth] = bus.daddr[req];
                bus.ccinv[oth]       = inv;
                bus.ramWEN           = bus.dWEN[oth];
                bus.ramaddr          = bus.daddr[oth];
                bus.ramstore         = bus.dstore[oth];
                bus.dload[req]       = bus.dstore[oth];
                if (bus.ramready) begin
                    bus.dwait  = 2'b00;
                    next_state = (state == C2C1) ? C2C2 : IDLE;
                end
            end

            RD1, RD2: begin
                if (state == RD1) begin
                    bus.ccwait[oth]      = 1'b1;
                    bus.ccsnoopaddr[oth] = bus.daddr[req];
                    bus.ccinv[oth]       = inv;
                end
                bus.ramREN     = 1'b1;
                bus.ramaddr    = bus.daddr[req];
                bus.dload[req] = bus.ramload;
                if (bus.ramready) begin
                    bus.dwait[req] = 1'b0;
                    next_state     = (state == RD1) ? RD2 : IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_coherence_ctrl.sv
// Randomized scoreboard bench for coherence_ctrl: cache/RAM agents drive the bus, a reference
// memory predicts read data, and a monitor checks every completed word and every snoop.
module tb_coherence_ctrl;
    localparam int LIM = 100;

    typedef struct packed {
        logic [31:0] addr;
        logic        inv;
    } snp_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    coherence_ctrl_if bus();

    coherence_ctrl dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // requester-side drive, snooper-side response, RAM and reference memory
    logic [1:0]       req_ren = '0, req_wen = '0, req_trans = '0, req_write = '0;
    logic [1:0][31:0] req_addr = '0, req_store = '0;
    logic [1:0]       snp_dirty = '0;
    logic [1:0][31:0] snp_base = '0;
    logic [31:0]      snp_data [2][2];
    int               snp_w [2];
    logic [31:0]      ram [1024];
    logic [31:0]      ref_mem [1024];
    int               ram_cnt = 0;
    int               ram_lat = 0;
    logic [1:0]       rd_act = '0;
    logic             abort = 1'b0;
    logic             rr_last = 1'b1;
    int               done_cyc [2];
    int               first_cyc [2];
    int               wb_cyc [4];

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    snp_t        snp_q0 [$];
    snp_t        snp_q1 [$];

    always_comb begin
        for (int j = 0; j < 2; j++) begin
            bus.dREN[j]    = req_ren[j];
            bus.ccwrite[j] = req_write[j];
            if (bus.ccwait[j]) begin
                bus.dWEN[j]    = snp_dirty[j] && (snp_w[j] < 2);
                bus.cctrans[j] = snp_dirty[j];
                bus.daddr[j]   = snp_base[j] + 32'(4 * snp_w[j]);
                bus.dstore[j]  = snp_data[j][snp_w[j] & 1];
            end else begin
                bus.dWEN[j]    = req_wen[j];
                bus.cctrans[j] = req_trans[j];
                bus.daddr[j]   = req_addr[j];
                bus.dstore[j]  = req_store[j];
            end
        end
    end

    always_comb bus.ramready = (bus.ramREN | bus.ramWEN) && (ram_cnt == ram_lat);
    always_comb bus.ramload  = ram[bus.ramaddr[11:2]];

    // RAM and snooper agents: sample mid-cycle, commit at the edge
    initial begin
        logic        s_rdy, s_wen, s_act;
        logic [31:0] s_addr, s_st;
        logic [1:0]  s_cw, s_dn;
        snp_w[0] = 0;
        snp_w[1] = 0;
        forever begin
            @(negedge CLK);
            s_rdy = bus.ramready; s_wen = bus.ramWEN; s_act = bus.ramREN | bus.ramWEN;
            s_addr = bus.ramaddr; s_st = bus.ramstore;
            s_cw = bus.ccwait; s_dn = ~bus.dwait;
            @(posedge CLK);
            if (nRST && s_rdy && s_wen) ram[s_addr[11:2]] = s_st;
            #1;
            ram_cnt = (nRST && s_act && !s_rdy) ? ram_cnt + 1 : 0;
            for (int j = 0; j < 2; j++)
                snp_w[j] = !s_cw[j] ? 0 : (s_dn[j] ? snp_w[j] + 1 : snp_w[j]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: no completion within %0d cycles", nm, LIM);
    endtask

    // Monitor: completed read words and snoop broadcasts against the scoreboard
    logic [1:0] cw_prev = '0;
    always @(negedge CLK) begin : mon
        logic [31:0] e;
        snp_t        s;
        for (int j = 0; j < 2; j++) begin
            if (rd_act[j] && !bus.dwait[j]) begin
                if ((j == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    checks++; errors++;
                    $display("FAIL dload_unexpected: core %0d got %h, nothing expected", j, bus.dload[j]);
                end else begin
                    e = (j == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk($sformatf("dload%0d", j), bus.dload[j], e);
                end
            end
            if (bus.ccwait[j] && !cw_prev[j]) begin
                if ((j == 0 ? snp_q0.size() : snp_q1.size()) == 0) begin
                    checks++; errors++;
                    $display("FAIL snoop_unexpected: core %0d addr %h", j, bus.ccsnoopaddr[j]);
                end else begin
                    s = (j == 0) ? snp_q0.pop_front() : snp_q1.pop_front();
                    chk($sformatf("snoopaddr%0d", j), bus.ccsnoopaddr[j], s.addr);
                    chk($sformatf("ccinv%0d", j), 32'(bus.ccinv[j]), 32'(s.inv));
                end
            end
        end
        cw_prev <= bus.ccwait;
    end

    task automatic do_read(input int i, input logic [31:0] base, input logic wr,
                           input logic dty, input bit chk_lat);
        int o, n, tot;
        logic [31:0] d0, d1, a1;
        snp_t s;
        o = 1 - i;
        d0 = $urandom; d1 = $urandom;
        a1 = base + 32'd4;
        snp_dirty[o] = dty; snp_base[o] = base;
        snp_data[o][0] = d0; snp_data[o][1] = d1;
        s.addr = base; s.inv = wr;
        if (o == 0) snp_q0.push_back(s); else snp_q1.push_back(s);
        if (i == 0) begin
            exp_q0.push_back(dty ? d0 : ref_mem[base[11:2]]);
            exp_q0.push_back(dty ? d1 : ref_mem[a1[11:2]]);
        end else begin
            exp_q1.push_back(dty ? d0 : ref_mem[base[11:2]]);
            exp_q1.push_back(dty ? d1 : ref_mem[a1[11:2]]);
        end
        rd_act[i] = 1'b1; req_ren[i] = 1'b1; req_trans[i] = 1'b1;
        req_write[i] = wr; req_addr[i] = base;
        tot = 0;
        for (int w = 0; w < 2; w++) begin
            n = 0;
            do begin @(negedge CLK); n++; end while (bus.dwait[i] && n < LIM && !abort);
            if (abort) break;
            if (bus.dwait[i]) begin fail_timeout("read_word"); break; end
            tot += n;
            if (w == 0) first_cyc[i] = cyc;
            done_cyc[i] = cyc;
            if (dty) ref_mem[(w == 0) ? base[11:2] : a1[11:2]] = (w == 0) ? d0 : d1;
            @(posedge CLK); #1;
            req_addr[i] = a1;
        end
        req_ren[i] = 1'b0; req_trans[i] = 1'b0; req_write[i] = 1'b0; rd_act[i] = 1'b0;
        rr_last = i[0];
        if (chk_lat && !abort) chk("read_latency", 32'(tot), 32'(2 + 2 * (ram_lat + 1)));
    endtask

    task automatic do_wb(input int i, input logic [31:0] base, input int nw, input bit chk_lat);
        int n;
        logic [31:0] a;
        a = base;
        req_wen[i] = 1'b1; req_trans[i] = 1'b0; req_addr[i] = a; req_store[i] = $urandom;
        for (int w = 0; w < nw; w++) begin
            n = 0;
            do begin @(negedge CLK); n++; end while (bus.dwait[i] && n < LIM);
            if (bus.dwait[i]) begin fail_timeout("wb_word"); break; end
            if (w < 4) wb_cyc[w] = cyc;
            if (chk_lat) chk("wb_latency", 32'(n), 32'((w == 0 ? 1 : 0) + ram_lat + 1));
            ref_mem[a[11:2]] = req_store[i];
            @(posedge CLK); #1;
            a = a + 32'd4;
            req_addr[i] = a; req_store[i] = $urandom;
        end
        req_wen[i] = 1'b0;
        rr_last = i[0];
        @(posedge CLK); #1;
    endtask

    task automatic tie(input logic [31:0] a0, input logic [31:0] a1);
        logic exp_w, got_w;
        exp_w = ~rr_last;
        fork
            do_read(0, a0, 1'b0, 1'b0, 1'b0);
            do_read(1, a1, 1'b0, 1'b0, 1'b0);
        join
        got_w = (done_cyc[0] < done_cyc[1]) ? 1'b0 : 1'b1;
        chk("tie_winner", 32'(got_w), 32'(exp_w));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dwait"}, 32'(bus.dwait), 32'h3);
        chk({tag, "_ccwait"}, 32'(bus.ccwait), 32'h0);
        chk({tag, "_ccinv"}, 32'(bus.ccinv), 32'h0);
        chk({tag, "_snpaddr"}, bus.ccsnoopaddr[0] | bus.ccsnoopaddr[1], 32'h0);
        chk({tag, "_dload"}, bus.dload[0] | bus.dload[1], 32'h0);
        chk({tag, "_ramstrobe"}, 32'({bus.ramREN, bus.ramWEN}), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] b;
        for (int w = 0; w < 1024; w++) begin
            ram[w] = $urandom;
            ref_mem[w] = ram[w];
        end
        #2;
        chk_reset_outputs("rst_async");
        @(posedge CLK); #1;
        nRST = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk_reset_outputs("rst_hold");
        end
        @(posedge CLK); #1;

        // ties: first after reset, then after a lone core-0 grant
        ram_lat = 0;
        tie(32'h010, 32'h020);
        do_read(0, 32'h030, 1'b0, 1'b0, 1'b1);
        tie(32'h040, 32'h050);

        do_read(0, 32'h100, 1'b0, 1'b0, 1'b1);
        do_read(1, 32'h200, 1'b1, 1'b1, 1'b1);

        // flush while the other core waits to read
        ram_lat = 2;
        fork
            do_wb(0, 32'h400, 4, 1'b1);
            do_read(1, 32'h300, 1'b0, 1'b0, 1'b0);
        join
        for (int w = 1; w < 4; w++) chk("flush_spacing", 32'(wb_cyc[w] - wb_cyc[w-1]), 32'd3);
        chk("read_after_flush", 32'(first_cyc[1] > wb_cyc[3]), 32'd1);

        // dREN without cctrans is never granted
        req_ren[0] = 1'b1; req_addr[0] = 32'h500;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("nogrant_strobes", 32'({bus.ramREN, bus.ramWEN, bus.ccwait}), 32'h0);
        end
        @(posedge CLK); #1;
        req_ren[0] = 1'b0;

        for (int t = 0; t < 30; t++) begin
            ram_lat = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0)
                do_wb($urandom_range(0, 1), 32'($urandom_range(0, 1019)) << 2,
                      $urandom_range(1, 4), 1'b1);
            else begin
                b = 32'($urandom_range(0, 511)) << 3;
                do_read($urandom_range(0, 1), b, 1'($urandom), 1'($urandom), 1'b1);
            end
        end

        // reset in the middle of a cache-to-cache transfer
        ram_lat = 2;
        fork
            do_read(1, 32'h280, 1'b1, 1'b1, 1'b0);
            begin
                n = 0;
                do begin @(negedge CLK); n++; end while (!(bus.ccwait[0] && bus.ramWEN) && n < LIM);
                if (!(bus.ccwait[0] && bus.ramWEN)) fail_timeout("reach_c2c");
                nRST = 1'b0;
                abort = 1'b1;
                #1;
                chk_reset_outputs("rst_c2c");
            end
        join
        exp_q0.delete(); exp_q1.delete(); snp_q0.delete(); snp_q1.delete();
        @(posedge CLK); #1;
        nRST = 1'b1;
        abort = 1'b0;
        rr_last = 1'b1;
        ram_lat = 1;
        do_read(0, 32'h600, 1'b0, 1'b1, 1'b1);
        tie(32'h700, 32'h708);

        for (int w = 0; w < 1024; w++) chk($sformatf("ram[%0d]", w), ram[w], ref_mem[w]);
        chk("exp_q_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        chk("snp_q_empty", 32'(snp_q0.size() + snp_q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
